// File: rtl/fc_pkg.sv
// Shared types and constants for the fully-connected layer datapath.
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MAC_LAT = 2;   // mac: en -> done
  localparam int MEM_LAT = 1;   // rd_en -> rdata
  localparam int FEAT_W  = 8;
  localparam int WGT_W   = 8;
  localparam int PROD_W  = 16;

endpackage

// File: rtl/fc_dot_seq.sv
// Dot-product sequencer for one FC neuron: walks the feature/weight
// memories, feeds the external mac and accumulates its products onto a bias.
module fc_dot_seq
  import fc_pkg::*;
#(
  parameter int IN_LEN = 784,
  parameter int ADDR_W = 10,
  parameter int ACC_W  = 26
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic signed [15:0]       bias,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [FEAT_W-1:0]        feat_rdata,
  input  logic [WGT_W-1:0]         wgt_rdata,
  output logic                     mac_en,
  output logic [FEAT_W-1:0]        mac_feature,
  output logic [WGT_W-1:0]         mac_weight,
  input  logic signed [PROD_W-1:0] mac_result,
  input  logic                     mac_done,
  output logic                     busy,
  output logic signed [ACC_W-1:0]  acc,
  output logic                     valid
);

  // Counters are one bit wider than the address so IN_LEN = 2^ADDR_W fits.
  localparam logic [ADDR_W:0] LAST  = (ADDR_W+1)'(IN_LEN - 1);
  localparam logic [ADDR_W:0] CNT_N = (ADDR_W+1)'(IN_LEN);

  state_t            state;
  logic [ADDR_W:0]   issue_cnt;
  logic [ADDR_W:0]   done_cnt;
  logic              acc_upd;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_ext;

  // Read data lands one cycle after rd_en, same cycle as mac_en.
  assign mac_feature = feat_rdata;
  assign mac_weight  = wgt_rdata;
  assign rd_addr     = issue_cnt[ADDR_W-1:0];

  assign acc_upd  = mac_done && (state == ISSUE || state == DRAIN);
  assign prod_ext = {{(ACC_W-PROD_W){mac_result[PROD_W-1]}}, mac_result};
  assign bias_ext = {{(ACC_W-16){bias[15]}}, bias};

  // Control FSM, read strobe, mac enable and accumulator.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      issue_cnt <= '0;
      done_cnt  <= '0;
      acc       <= '0;
      rd_en     <= 1'b0;
      mac_en    <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
    end else begin
      mac_en <= rd_en;
      valid  <= 1'b0;
      if (acc_upd) begin
        acc      <= acc + prod_ext;
        done_cnt <= done_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ISSUE;
            acc       <= bias_ext;
            issue_cnt <= '0;
            done_cnt  <= '0;
            rd_en     <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ISSUE: begin
          // Hold the counter on the last address so rd_addr never wraps.
          if (issue_cnt == LAST) begin
            state <= DRAIN;
            rd_en <= 1'b0;
          end else begin
            issue_cnt <= issue_cnt + 1'b1;
          end
        end
        DRAIN: begin
          // Leave on the edge that absorbs the final product so valid
          // follows the last mac_done with no dead cycle.
          if (done_cnt == CNT_N || (acc_upd && done_cnt == LAST)) begin
            state <= DONE;
            valid <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_dot_seq.sv
// Bench for fc_dot_seq: three instances (IN_LEN 4, 1, 784), each with its
// own feature/weight memories and a 2-stage mac model.
module tb_fc_dot_seq;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic               start_v   [NI];
  logic signed [15:0] bias_v    [NI];
  logic               rd_en_v   [NI];
  logic [9:0]         rd_addr_v [NI];
  logic               mac_en_v  [NI];
  logic [7:0]         mf_v      [NI];
  logic [7:0]         mw_v      [NI];
  logic               busy_v    [NI];
  logic signed [25:0] acc_v     [NI];
  logic               valid_v   [NI];

  logic [7:0] fmem [NI][1024];
  logic [7:0] wmem [NI][1024];

  int vectors = 0;
  int miscompares = 0;

  function automatic int len_of(input int g);
    return (g == 0) ? 4 : (g == 1) ? 1 : 784;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_i
    localparam int N = (g == 0) ? 4 : (g == 1) ? 1 : 784;
    logic [7:0]         frd, wrd;
    logic               s1v, s2v;
    logic signed [15:0] s1p, s2p;

    // memories: registered read, one cycle latency
    always @(posedge clk) begin
      if (rd_en_v[g]) begin
        frd <= fmem[g][rd_addr_v[g]];
        wrd <= wmem[g][rd_addr_v[g]];
      end
    end

    // mac model: unsigned feature x signed weight, 2 cycles en->done
    always @(posedge clk) begin
      if (!rstn) begin
        s1v <= 1'b0;
        s2v <= 1'b0;
        s1p <= '0;
        s2p <= '0;
      end else begin
        s1v <= mac_en_v[g];
        s1p <= $signed({1'b0, mf_v[g]}) * $signed(mw_v[g]);
        s2v <= s1v;
        s2p <= s1p;
      end
    end

    fc_dot_seq #(.IN_LEN(N), .ADDR_W(10), .ACC_W(26)) u_dut (
      .clk         (clk),
      .rstn        (rstn),
      .start       (start_v[g]),
      .bias        (bias_v[g]),
      .rd_en       (rd_en_v[g]),
      .rd_addr     (rd_addr_v[g]),
      .feat_rdata  (frd),
      .wgt_rdata   (wrd),
      .mac_en      (mac_en_v[g]),
      .mac_feature (mf_v[g]),
      .mac_weight  (mw_v[g]),
      .mac_result  (s2p),
      .mac_done    (s2v),
      .busy        (busy_v[g]),
      .acc         (acc_v[g]),
      .valid       (valid_v[g])
    );
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: bias + sum(feature * weight), wrapped to 26 bits.
  function automatic logic signed [25:0] ref_acc(input int g, input int b);
    int s;
    s = b;
    for (int i = 0; i < len_of(g); i++)
      s += int'(fmem[g][i]) * int'($signed(wmem[g][i]));
    return s[25:0];
  endfunction

  task automatic fill_rand(input int g);
    for (int i = 0; i < len_of(g); i++) begin
      fmem[g][i] = 8'($urandom);
      wmem[g][i] = 8'($urandom);
    end
  endtask

  // One start pulse, then watch IN_LEN+8 cycles (cycle 1 = first after start).
  task automatic run(input int g, input logic signed [15:0] b, input bit pulse,
                     output int lat, output logic signed [25:0] acc_at,
                     output logic signed [25:0] acc_end, output int nval,
                     output int busy_fall, output int addr_bad);
    int n;
    n = len_of(g);
    lat = -1; nval = 0; busy_fall = -1; addr_bad = 0; acc_at = 'x;
    @(negedge clk);
    bias_v[g]  = b;
    start_v[g] = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= n + 8; c++) begin
      @(negedge clk);
      if (c <= n) begin
        if (rd_en_v[g] !== 1'b1 || rd_addr_v[g] !== 10'(c - 1)) addr_bad++;
      end else if (c == n + 1) begin
        if (rd_en_v[g] !== 1'b0) addr_bad++;
      end
      if (valid_v[g] === 1'b1) begin
        nval++;
        if (lat < 0) begin
          lat    = c;
          acc_at = acc_v[g];
        end
      end
      if (busy_fall < 0 && busy_v[g] === 1'b0) busy_fall = c;
      start_v[g] = pulse && (c == 2 || c == 6);
    end
    acc_end    = acc_v[g];
    start_v[g] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nv, bf, ab, v0, v1, v2;
    logic signed [25:0] a, ae, a0, e;
    logic signed [15:0] b;
    int vq[$];

    rstn = 1'b0;
    for (int g = 0; g < NI; g++) begin
      start_v[g] = 1'b0;
      bias_v[g]  = '0;
      for (int i = 0; i < 1024; i++) begin
        fmem[g][i] = '0;
        wmem[g][i] = '0;
      end
    end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk("rst_busy",  busy_v[g],  0);
      chk("rst_acc",   acc_v[g],   0);
      chk("rst_rd_en", rd_en_v[g], 0);
      chk("rst_mac_en", mac_en_v[g], 0);
      chk("rst_valid", valid_v[g], 0);
      chk("rst_addr",  rd_addr_v[g], 0);
    end

    // directed IN_LEN=4
    fmem[0][0] = 8'd1; fmem[0][1] = 8'd2; fmem[0][2] = 8'd3; fmem[0][3] = 8'd4;
    wmem[0][0] = 8'd1; wmem[0][1] = 8'hFF; wmem[0][2] = 8'd2; wmem[0][3] = 8'hFE;
    run(0, 16'sd5, 1'b0, lat, a, ae, nv, bf, ab);
    chk("dir_addr_seq", ab, 0);
    chk("dir_latency", lat, 8);
    chk("dir_acc_model", a, ref_acc(0, 5));
    chk("dir_acc_const", a, 2);
    chk("dir_nvalid", nv, 1);
    chk("dir_busy_fall", bf, 9);
    chk("dir_acc_hold", ae, 2);

    // random IN_LEN=4
    repeat (6) begin
      fill_rand(0);
      b = 16'($urandom);
      run(0, b, 1'b0, lat, a, ae, nv, bf, ab);
      chk("rnd4_acc", a, ref_acc(0, b));
      chk("rnd4_latency", lat, 8);
      chk("rnd4_nvalid", nv, 1);
      chk("rnd4_addr_seq", ab, 0);
    end

    // IN_LEN=1 boundary
    fmem[1][0] = 8'd255; wmem[1][0] = 8'd127;
    run(1, -16'sd1, 1'b0, lat, a, ae, nv, bf, ab);
    chk("len1_latency", lat, 5);
    chk("len1_acc_const", a, 32384);
    chk("len1_acc_model", a, ref_acc(1, -1));
    chk("len1_busy_fall", bf, 6);
    chk("len1_addr_seq", ab, 0);
    repeat (3) begin
      fill_rand(1);
      b = 16'($urandom);
      run(1, b, 1'b0, lat, a, ae, nv, bf, ab);
      chk("len1_rnd_acc", a, ref_acc(1, b));
    end

    // IN_LEN=784 worst-case magnitude
    for (int i = 0; i < 784; i++) begin
      fmem[2][i] = 8'd255;
      wmem[2][i] = 8'h80;
    end
    run(2, 16'sd0, 1'b0, lat, a, ae, nv, bf, ab);
    chk("big_acc_b0", a, -25589760);
    chk("big_acc_b0_model", a, ref_acc(2, 0));
    chk("big_latency", lat, 788);
    chk("big_busy_fall", bf, 789);
    chk("big_addr_seq", ab, 0);
    run(2, 16'sd32767, 1'b0, lat, a, ae, nv, bf, ab);
    chk("big_acc_bmax", a, -25556993);
    fill_rand(2);
    b = 16'($urandom);
    run(2, b, 1'b0, lat, a, ae, nv, bf, ab);
    chk("big_rnd_acc", a, ref_acc(2, b));

    // start pulses while busy are ignored
    fill_rand(0);
    b = 16'($urandom);
    run(0, b, 1'b0, lat, a0, ae, nv, bf, ab);
    run(0, b, 1'b1, lat, a, ae, nv, bf, ab);
    chk("ign_nvalid", nv, 1);
    chk("ign_acc_same", a, a0);
    chk("ign_acc_model", a, ref_acc(0, b));
    chk("ign_latency", lat, 8);

    // reset in cycle 3 of ISSUE
    fill_rand(0);
    @(negedge clk);
    bias_v[0]  = 16'sh4321;
    start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_pre_busy", busy_v[0], 1);
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy_v[0], 0);
    chk("abort_acc", acc_v[0], 0);
    chk("abort_rd_en", rd_en_v[0], 0);
    chk("abort_mac_en", mac_en_v[0], 0);
    chk("abort_valid", valid_v[0], 0);
    rstn = 1'b1;
    fill_rand(0);
    b = 16'($urandom);
    run(0, b, 1'b0, lat, a, ae, nv, bf, ab);
    chk("abort_fresh_acc", a, ref_acc(0, b));
    chk("abort_fresh_latency", lat, 8);
    chk("abort_fresh_nvalid", nv, 1);

    // start held high: back-to-back neurons
    fill_rand(0);
    b = 16'($urandom);
    e = ref_acc(0, b);
    @(negedge clk);
    bias_v[0]  = b;
    start_v[0] = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (valid_v[0] === 1'b1) begin
        vq.push_back(c);
        chk("b2b_acc", acc_v[0], e);
      end
      if (c == 26) start_v[0] = 1'b0;
    end
    v0 = (vq.size() > 0) ? vq[0] : -1;
    v1 = (vq.size() > 1) ? vq[1] : -1;
    v2 = (vq.size() > 2) ? vq[2] : -1;
    chk("b2b_count", vq.size(), 3);
    chk("b2b_valid0", v0, 8);
    chk("b2b_valid1", v1, 17);
    chk("b2b_valid2", v2, 26);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
